// File: rtl/fifo_axi_write_drain.sv
// -----------------------------------------------------------------------------
// fifo_axi_write_drain
//
// Drains the store FIFO into memory. The entry at the FIFO head is captured,
// issued as one single-beat AXI3 write (AW and W in parallel), and once the
// B response arrives `complete` pulses so the FIFO retires that entry. At most
// one write is outstanding at any time.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   fifo_empty            FIFO has no valid entry
//   fifo_rdata_pack       head entry {size[70:68], wstrb[67:64], addr[63:32], wdata[31:0]}
//   complete              one-cycle retire pulse back to the FIFO
//   aw*                   AXI3 write address channel (single beat, INCR)
//   w*                    AXI3 write data channel (wlast always set)
//   b*                    AXI3 write response channel (bid is ignored)
//   drained               engine idle and FIFO empty: all stores reached memory
//   bus_error             sticky: some B response carried a non-OKAY bresp
// -----------------------------------------------------------------------------
module fifo_axi_write_drain #(
  parameter int         PACK_WIDTH = 71,
  parameter logic [3:0] AXI_WID    = 4'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [PACK_WIDTH-1:0] fifo_rdata_pack,
  output logic                  complete,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  drained,
  output logic                  bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  size_q, size_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        bus_error_q, bus_error_d;

  logic        aw_hs_s;
  logic        w_hs_s;
  logic        unused_bid_s;

  assign aw_hs_s      = awvalid_q && awready;
  assign w_hs_s       = wvalid_q && wready;
  // Responses are never matched by ID: only one write can be in flight.
  assign unused_bid_s = ^bid;

  // State and transaction registers; reset drops every valid immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      strb_q      <= 4'd0;
      size_q      <= 3'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      size_q      <= size_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next-state logic for the IDLE -> SEND -> WAIT_B write sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    size_d      = size_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bus_error_d = bus_error_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          // Capture the head now: the pack changes as soon as it retires.
          data_d    = fifo_rdata_pack[31:0];
          addr_d    = fifo_rdata_pack[63:32];
          strb_d    = fifo_rdata_pack[67:64];
          size_d    = fifo_rdata_pack[70:68];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (aw_hs_s) begin
          aw_done_d = 1'b1;
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          w_done_d = 1'b1;
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        // A handshake landing on this very edge counts as done.
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d = WAIT_B;
        end else begin
          state_d = SEND;
        end
      end

      WAIT_B: begin
        if (bvalid) begin
          state_d = IDLE;
          // Error responses still retire the entry; the flag is sticky.
          if (bresp != 2'b00) begin
            bus_error_d = 1'b1;
          end else begin
            bus_error_d = bus_error_q;
          end
        end else begin
          state_d = WAIT_B;
        end
      end

      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  // complete is combinational so the FIFO pops on the same edge as the B handshake.
  assign bready    = (state_q == WAIT_B);
  assign complete  = (state_q == WAIT_B) && bvalid;
  assign drained   = (state_q == IDLE) && fifo_empty;
  assign bus_error = bus_error_q;

  assign awid      = AXI_WID;
  assign awaddr    = addr_q;
  assign awlen     = 8'd0;
  assign awsize    = size_q;
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign awvalid   = awvalid_q;

  assign wid       = AXI_WID;
  assign wdata     = data_q;
  assign wstrb     = strb_q;
  assign wlast     = 1'b1;
  assign wvalid    = wvalid_q;

endmodule

// File: tb/tb_fifo_axi_write_drain.sv
// -----------------------------------------------------------------------------
// Bench for fifo_axi_write_drain. The bench owns the store FIFO (a queue), an
// AXI slave responder with programmable ready/response delays, and a
// transaction-level model of what the engine must show on every cycle.
// Inputs change 1 time unit after the rising edge; outputs are compared on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_axi_write_drain;

  typedef struct packed {
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [70:0] fifo_rdata_pack;
  logic        complete;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        drained;
  logic        bus_error;

  always #5 clk = ~clk;

  fifo_axi_write_drain #(.PACK_WIDTH(71), .AXI_WID(4'd1)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata_pack(fifo_rdata_pack),
    .complete(complete),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .drained(drained), .bus_error(bus_error)
  );

  // Store FIFO contents, head at index 0
  entry_t q[$];

  // Model: one write owed on AW, one on W, then one response awaited
  bit m_busy, m_aw, m_w, m_b, m_err;

  // Responder controls
  int aw_dly, w_dly, b_dly, aw_cnt, w_cnt, b_cnt, err_at;
  bit spur;

  // Observations
  int n_vec, n_err, cyc;
  int n_aw_hi, n_w_hi, n_cmp, n_cmp_bv;
  int aw_rise_cyc, aw_hs_cyc, w_hs_cyc, b_rise_cyc, err_rise_cyc;
  int cmp_cyc[$];
  logic [31:0] issued[$];
  bit prev_aw, prev_b, prev_err;

  // Inputs as seen at the falling edge (stable through the next rising edge)
  bit s_awready, s_wready, s_bvalid, s_empty, s_cmp;
  logic [1:0] s_bresp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty      = (q.size() == 0);
    fifo_rdata_pack = (q.size() != 0) ? q[0] : 71'd0;
  endtask

  task automatic push(input entry_t e);
    q.push_back(e);
    refresh_fifo();
  endtask

  task automatic model_clear();
    m_busy = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_b = 1'b0; m_err = 1'b0;
  endtask

  task automatic compare();
    entry_t h;
    h = '0;
    if (q.size() != 0) h = q[0];
    chk("awvalid",   32'(awvalid),   32'(m_aw));
    chk("wvalid",    32'(wvalid),    32'(m_w));
    chk("bready",    32'(bready),    32'(m_b));
    chk("complete",  32'(complete),  32'(m_b && bvalid));
    chk("drained",   32'(drained),   32'(!m_busy && q.size() == 0));
    chk("bus_error", 32'(bus_error), 32'(m_err));
    chk("aw_consts", 32'({awid, awlen, awburst, awlock, awcache, awprot}),
        32'({4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
    chk("wid", 32'(wid), 32'd1);
    if (m_aw) begin
      chk("awaddr", awaddr, h.addr);
      chk("awsize", 32'(awsize), 32'(h.size));
    end
    if (m_w) begin
      chk("wdata", wdata, h.data);
      chk("wstrb", 32'(wstrb), 32'(h.strb));
      chk("wlast", 32'(wlast), 32'd1);
    end
    if (awvalid) n_aw_hi++;
    if (awvalid && !prev_aw) aw_rise_cyc = cyc;
    if (awvalid && awready) aw_hs_cyc = cyc;
    if (wvalid) n_w_hi++;
    if (wvalid && wready) begin
      w_hs_cyc = cyc;
      issued.push_back(wdata);
    end
    if (bready && !prev_b) b_rise_cyc = cyc;
    if (complete) begin
      n_cmp++;
      cmp_cyc.push_back(cyc);
      if (bvalid) n_cmp_bv++;
    end
    if (bus_error && !prev_err) err_rise_cyc = cyc;
    prev_aw  = awvalid;
    prev_b   = bready;
    prev_err = bus_error;
    s_awready = awready; s_wready = wready; s_bvalid = bvalid;
    s_bresp   = bresp;   s_empty  = fifo_empty; s_cmp = complete;
  endtask

  // One clock: compare at the falling edge, then advance FIFO, model and responder.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    compare();
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (!m_busy) begin
        if (!s_empty) begin
          m_busy = 1'b1; m_aw = 1'b1; m_w = 1'b1;
        end
      end else if (m_b) begin
        if (s_bvalid) begin
          m_busy = 1'b0; m_b = 1'b0;
          if (s_bresp != 2'b00) m_err = 1'b1;
        end
      end else begin
        if (m_aw && s_awready) m_aw = 1'b0;
        if (m_w && s_wready) m_w = 1'b0;
        if (!m_aw && !m_w) m_b = 1'b1;
      end
      if (s_cmp && q.size() != 0) void'(q.pop_front());
    end
    refresh_fifo();
    if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin
      bvalid = (b_cnt >= b_dly);
      bresp  = (bvalid && n_cmp == err_at) ? 2'b10 : 2'b00;
      b_cnt++;
    end else begin
      bvalid = spur; bresp = 2'b00; b_cnt = 0;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (q.size() == 0 && drained === 1'b1 && !m_busy) done = 1'b1;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    entry_t e;
    int a0, w0, c0, cb0, i0, t0;
    logic [31:0] d3[4];
    bit seen;

    n_vec = 0; n_err = 0; cyc = 0;
    n_aw_hi = 0; n_w_hi = 0; n_cmp = 0; n_cmp_bv = 0;
    aw_rise_cyc = 0; aw_hs_cyc = 0; w_hs_cyc = 0; b_rise_cyc = 0; err_rise_cyc = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    err_at = -1; spur = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd5;
    model_clear();
    reset = 1'b1;
    refresh_fifo();
    repeat (3) cycle();
    chk("rst_awaddr",  awaddr, 32'd0);
    chk("rst_wdata",   wdata,  32'd0);
    chk("rst_wstrb",   32'(wstrb), 32'd0);
    chk("rst_awsize",  32'(awsize), 32'd0);
    chk("rst_drained", 32'(drained), 32'd1);
    reset = 1'b0;
    repeat (2) cycle();

    // Single entry, everything ready at once
    a0 = n_aw_hi; w0 = n_w_hi; cb0 = n_cmp;
    e = '{size: 3'd2, strb: 4'hF, addr: 32'h1FC0_0010, data: 32'hDEAD_BEEF};
    c0 = cyc + 1;
    push(e);
    wait_idle("t1_done", 20);
    chk("t1_aw_cycles",  32'(n_aw_hi - a0), 32'd1);
    chk("t1_w_cycles",   32'(n_w_hi - w0),  32'd1);
    chk("t1_aw_latency", 32'(aw_rise_cyc),  32'(c0 + 1));
    chk("t1_cmp_count",  32'(n_cmp - cb0),  32'd1);
    chk("t1_cmp_cycle",  32'(cmp_cyc[$]),   32'(c0 + 2));
    chk("t1_wdata",      issued[$],         32'hDEAD_BEEF);
    chk("t1_drained",    32'(drained),      32'd1);

    // AW stalled three cycles, W immediate
    aw_dly = 3; w_dly = 0;
    a0 = n_aw_hi; w0 = n_w_hi;
    push('{size: 3'd1, strb: 4'h3, addr: 32'h0000_2000, data: 32'h1111_2222});
    wait_idle("t2a_done", 20);
    chk("t2a_aw_cycles", 32'(n_aw_hi - a0), 32'd4);
    chk("t2a_w_cycles",  32'(n_w_hi - w0),  32'd1);
    chk("t2a_w_first",   32'(w_hs_cyc),     32'(aw_rise_cyc));
    chk("t2a_bready",    32'(b_rise_cyc),   32'(aw_hs_cyc + 1));

    // W stalled three cycles, AW immediate
    aw_dly = 0; w_dly = 3;
    a0 = n_aw_hi; w0 = n_w_hi;
    push('{size: 3'd0, strb: 4'h1, addr: 32'h0000_3003, data: 32'h3333_4444});
    wait_idle("t2b_done", 20);
    chk("t2b_aw_cycles", 32'(n_aw_hi - a0), 32'd1);
    chk("t2b_w_cycles",  32'(n_w_hi - w0),  32'd4);
    chk("t2b_bready",    32'(b_rise_cyc),   32'(w_hs_cyc + 1));

    // Both handshakes on the same edge; bvalid asserted early must be ignored
    aw_dly = 2; w_dly = 2; spur = 1'b1;
    a0 = n_aw_hi; w0 = n_w_hi; cb0 = n_cmp;
    push('{size: 3'd2, strb: 4'hC, addr: 32'h0000_4000, data: 32'h5555_6666});
    wait_idle("t2c_done", 20);
    chk("t2c_aw_cycles", 32'(n_aw_hi - a0), 32'd3);
    chk("t2c_w_cycles",  32'(n_w_hi - w0),  32'd3);
    chk("t2c_same_edge", 32'(aw_hs_cyc),    32'(w_hs_cyc));
    chk("t2c_bready",    32'(b_rise_cyc),   32'(aw_hs_cyc + 1));
    chk("t2c_cmp_count", 32'(n_cmp - cb0),  32'd1);
    spur = 1'b0; aw_dly = 0; w_dly = 0;
    cycle();

    // Four entries back to back, slow responses
    b_dly = 5;
    d3[0] = 32'hA0A0_0001; d3[1] = 32'hB1B1_0002; d3[2] = 32'hC2C2_0003; d3[3] = 32'hD3D3_0004;
    cb0 = n_cmp; t0 = n_cmp_bv; i0 = issued.size();
    for (int k = 0; k < 4; k++)
      push('{size: 3'd2, strb: 4'hF, addr: 32'h0000_1000 + 32'(4 * k), data: d3[k]});
    wait_idle("t3_done", 80);
    chk("t3_cmp_count", 32'(n_cmp - cb0),    32'd4);
    chk("t3_cmp_bv",    32'(n_cmp_bv - t0),  32'd4);
    chk("t3_issued",    32'(issued.size() - i0), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_order%0d", k), (issued.size() > i0 + k) ? issued[i0 + k] : 32'd0, d3[k]);
    chk("t3_drained",   32'(drained),        32'd1);

    // SLVERR on the second of three writes
    b_dly = 1;
    cb0 = n_cmp; i0 = issued.size();
    err_at = n_cmp + 1;
    for (int k = 0; k < 3; k++)
      push('{size: 3'd2, strb: 4'hF, addr: 32'h0000_5000 + 32'(4 * k), data: 32'hE000_0000 + 32'(k)});
    wait_idle("t4_done", 60);
    err_at = -1;
    chk("t4_cmp_count", 32'(n_cmp - cb0), 32'd3);
    chk("t4_issued",    32'(issued.size() - i0), 32'd3);
    chk("t4_third",     issued[$], 32'hE000_0002);
    chk("t4_err_edge",  32'(err_rise_cyc),
        (cmp_cyc.size() > cb0 + 1) ? 32'(cmp_cyc[cb0 + 1] + 1) : 32'hFFFF_FFFF);
    chk("t4_sticky",    32'(bus_error), 32'd1);

    // Reset while AW is stalled in SEND
    b_dly = 0; aw_dly = 50;
    seen = 1'b0;
    push('{size: 3'd2, strb: 4'h6, addr: 32'h0000_6000, data: 32'h7777_8888});
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      if (awvalid === 1'b1) seen = 1'b1;
    end
    chk("t5_in_send", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    model_clear();
    chk("t5_rst_awvalid",  32'(awvalid),  32'd0);
    chk("t5_rst_wvalid",   32'(wvalid),   32'd0);
    chk("t5_rst_complete", 32'(complete), 32'd0);
    chk("t5_rst_buserr",   32'(bus_error), 32'd0);
    chk("t5_rst_awaddr",   awaddr, 32'd0);
    repeat (2) cycle();
    reset = 1'b0; aw_dly = 0;
    cb0 = n_cmp; i0 = issued.size();
    wait_idle("t5_done", 20);
    chk("t5_cmp_count", 32'(n_cmp - cb0), 32'd1);
    chk("t5_issued",    32'(issued.size() - i0), 32'd1);
    chk("t5_relaunch",  issued[$], 32'h7777_8888);
    chk("t5_drained",   32'(drained), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
